wbc_init_seq: RTL
=================

Name: wbc_init_seq

Overview:
- Reset/initialisation sequencer between the reset generator (DCLO/ACLO) and the CPU plus bus peripherals.
- Releases per-device init lines in a fixed order, waits for each device's ready with a timeout, then gates CPU run and raises power-up/power-fail trap strobes.
- Also executes the CPU RESET instruction as a timed bus INIT pulse with a completion handshake.
- Runs entirely in the sys_clk domain.

Parameters:
- NDEV, 4, number of sequenced devices (1..8); device 0 is released first.
- INIT_WIDTH, 16, sys_clk cycles of bus INIT for a software RESET (>=2).
- DEV_TIMEOUT, 1000, max sys_clk cycles to wait for any device ready (>=2).
- CNT_W, log2(max(INIT_WIDTH,DEV_TIMEOUT)), shared counter width (derived, localparam).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- dclo_in  in  1  DCLO from reset generator, sys_clk-synchronous, 1 = power not good
- aclo_in  in  1  ACLO, sys_clk-synchronous, 1 = AC low
- cpu_reset_req  in  1  one-cycle strobe from the CPU RESET instruction
- dev_ready  in  NDEV  per-device init-complete, level
- dev_init  out  NDEV  per-device init, 1 = held in init
- bus_init  out  1  bus INIT during a software RESET
- cpu_run  out  1  CPU may execute
- pwrup_trap  out  1  one-cycle strobe: take power-up vector
- pwrfail_trap  out  1  one-cycle strobe: ACLO fell while running
- cpu_reset_ack  out  1  one-cycle strobe: software RESET complete
- timeout_err  out  1  sticky flag: a device ready wait expired
- seq_state  out  3  current FSM state, for debug

Behaviour:
- sys_rst_n low (async):
  - state DCLO; dev_init all 1; bus_init 0; cpu_run 0; all strobes 0; timeout_err 0; counter and index 0.
- dclo_in = 1 in any state forces DCLO on the next edge.
  - This has priority over every other event, including a reset mid-sequence or mid-SWINIT.
  - dev_init is set all-1 and cpu_run 0 in that same transition.
- States:
  - DCLO (0): wait for dclo_in = 0, then go to STAGE with idx=0 and cnt=0.
  - STAGE (1):
    - dev_init[idx] and all lower indices are 0; higher indices stay 1.
    - Each cycle, if dev_ready[idx] = 1, or cnt = DEV_TIMEOUT-1 (which also sets timeout_err), then idx++ and cnt=0. Otherwise cnt++.
    - After idx = NDEV-1 is advanced, go to WACLO.
    - A device whose ready is already high costs exactly 1 cycle.
  - WACLO (2): wait for aclo_in = 0. Then pwrup_trap = 1 for one cycle and cpu_run = 1 on that same edge; go to RUN.
  - RUN (3):
    - aclo_in 0->1 (previous-cycle register): pwrfail_trap for one cycle; go to PFAIL.
    - Otherwise cpu_reset_req: cpu_run = 0, bus_init = 1, dev_init all 1, cnt = 0; go to SWINIT.
    - If ACLO rise and cpu_reset_req occur together, ACLO wins and the request is dropped.
  - PFAIL (4): cpu_run stays 1 so the trap handler can run. Wait for dclo_in (handled by the priority rule). cpu_reset_req is ignored.
  - SWINIT (5):
    - Hold bus_init = 1 and dev_init all 1 for exactly INIT_WIDTH cycles.
    - Then release bus_init and all dev_init together, cnt = 0; go to SWWAIT.
    - cpu_reset_req is ignored.
  - SWWAIT (6):
    - Wait until dev_ready is all 1, or cnt = DEV_TIMEOUT-1 (sets timeout_err).
    - Then cpu_reset_ack for one cycle and cpu_run = 1; go to RUN.
    - ACLO rise here: pwrfail_trap, cpu_run = 1, go to PFAIL.
- timeout_err clears only on sys_rst_n.
- All outputs are registered. seq_state carries the encodings listed above.
- Counter saturates, never wraps. idx width is log2(NDEV), minimum 1.

Optional Feature:
- WBC_INIT_STAGED_EN defined: ordered STAGE release as described above.
- Not defined: STAGE releases all dev_init together on entry and waits for dev_ready all-1 or timeout (single wait). WACLO onward is unchanged. idx logic is removed.

Test Plan:
- Power-up, NDEV=4, staged. dclo 1->0 at t0; devices raise ready 3, 5, 1, 2 cycles after their release; aclo=0. Expect dev_init bits clear in order 0..3, pwrup_trap one cycle, cpu_run=1, timeout_err=0.
- Device 2 never ready, DEV_TIMEOUT=8. Expect dev_init[3] released exactly 8 cycles after dev_init[2], timeout_err=1 sticky, cpu_run eventually 1.
- RUN, cpu_reset_req pulse. Expect cpu_run=0 and bus_init=1 for exactly 16 cycles; then after all ready, cpu_reset_ack one cycle and cpu_run=1. A second req during SWINIT is ignored.
- RUN, aclo 0->1 in the same cycle as cpu_reset_req. Expect pwrfail_trap one cycle, no bus_init, state PFAIL. Then dclo=1 gives dev_init=all-1 and cpu_run=0 next edge.
- dclo=1 mid-STAGE (idx=2) and mid-SWINIT. Expect immediate DCLO with all dev_init=1, and a restart from idx=0 after dclo=0.
- sys_rst_n pulsed low mid-RUN. Expect all outputs at reset values asynchronously, timeout_err cleared.

Source files
------------

// File: rtl/wbc_init_seq.sv
// Power-up / software-RESET initialisation sequencer for the CPU and bus devices.
// Define WBC_INIT_STAGED_EN for ordered per-device release; otherwise all devices release together.
module wbc_init_seq #(
    parameter int unsigned NDEV        = 4,
    parameter int unsigned INIT_WIDTH  = 16,
    parameter int unsigned DEV_TIMEOUT = 1000
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            dclo_in,
    input  logic            aclo_in,
    input  logic            cpu_reset_req,
    input  logic [NDEV-1:0] dev_ready,
    output logic [NDEV-1:0] dev_init,
    output logic            bus_init,
    output logic            cpu_run,
    output logic            pwrup_trap,
    output logic            pwrfail_trap,
    output logic            cpu_reset_ack,
    output logic            timeout_err,
    output logic [2:0]      seq_state
);

    localparam int unsigned CNT_MAX = (INIT_WIDTH > DEV_TIMEOUT) ? INIT_WIDTH : DEV_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(DEV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WIDTH - 1);
    localparam logic [NDEV-1:0]  ALL_ONES  = {NDEV{1'b1}};

`ifdef WBC_INIT_STAGED_EN
    localparam int unsigned     IDX_W    = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDEV - 1);
`endif

    typedef enum logic [2:0] {
        ST_DCLO   = 3'd0,
        ST_STAGE  = 3'd1,
        ST_WACLO  = 3'd2,
        ST_RUN    = 3'd3,
        ST_PFAIL  = 3'd4,
        ST_SWINIT = 3'd5,
        ST_SWWAIT = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [NDEV-1:0]  dev_init_d;
    logic             bus_init_d, cpu_run_d;
    logic             pwrup_d, pwrfail_d, ack_d, timeout_d;
    logic             aclo_q, aclo_rise;
`ifdef WBC_INIT_STAGED_EN
    logic [IDX_W-1:0] idx_q, idx_d;
`endif

    assign aclo_rise = aclo_in & ~aclo_q;
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign seq_state = state_q;

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_DCLO;
            cnt_q         <= '0;
            dev_init      <= ALL_ONES;
            bus_init      <= 1'b0;
            cpu_run       <= 1'b0;
            pwrup_trap    <= 1'b0;
            pwrfail_trap  <= 1'b0;
            cpu_reset_ack <= 1'b0;
            timeout_err   <= 1'b0;
            aclo_q        <= 1'b0;
`ifdef WBC_INIT_STAGED_EN
            idx_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dev_init      <= dev_init_d;
            bus_init      <= bus_init_d;
            cpu_run       <= cpu_run_d;
            pwrup_trap    <= pwrup_d;
            pwrfail_trap  <= pwrfail_d;
            cpu_reset_ack <= ack_d;
            timeout_err   <= timeout_d;
            aclo_q        <= aclo_in;
`ifdef WBC_INIT_STAGED_EN
            idx_q         <= idx_d;
`endif
        end
    end

    // Next-state and next-output logic; DCLO overrides every state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dev_init_d = dev_init;
        bus_init_d = bus_init;
        cpu_run_d  = cpu_run;
        pwrup_d    = 1'b0;
        pwrfail_d  = 1'b0;
        ack_d      = 1'b0;
        timeout_d  = timeout_err;
`ifdef WBC_INIT_STAGED_EN
        idx_d      = idx_q;
`endif

        if (dclo_in) begin
            state_d    = ST_DCLO;
            cnt_d      = '0;
            dev_init_d = ALL_ONES;
            bus_init_d = 1'b0;
            cpu_run_d  = 1'b0;
`ifdef WBC_INIT_STAGED_EN
            idx_d      = '0;
`endif
        end else begin
            case (state_q)
                ST_DCLO: begin
                    state_d = ST_STAGE;
                    cnt_d   = '0;
`ifdef WBC_INIT_STAGED_EN
                    idx_d      = '0;
                    dev_init_d = ALL_ONES << 1;
`else
                    dev_init_d = '0;
`endif
                end
                ST_STAGE: begin
`ifdef WBC_INIT_STAGED_EN
                    if (dev_ready[idx_q] || (cnt_q == TMO_LAST)) begin
                        if (!dev_ready[idx_q]) timeout_d = 1'b1;
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d    = ST_WACLO;
                            idx_d      = '0;
                            dev_init_d = '0;
                        end else begin
                            idx_d      = idx_q + IDX_W'(1);
                            dev_init_d = ALL_ONES << (32'(idx_q) + 32'd2);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    if ((&dev_ready) || (cnt_q == TMO_LAST)) begin
                        if (!(&dev_ready)) timeout_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_WACLO;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`endif
                end
                ST_WACLO: begin
                    if (!aclo_in) begin
                        pwrup_d   = 1'b1;
                        cpu_run_d = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (aclo_rise) begin
                        pwrfail_d = 1'b1;
                        state_d   = ST_PFAIL;
                    end else if (cpu_reset_req) begin
                        cpu_run_d  = 1'b0;
                        bus_init_d = 1'b1;
                        dev_init_d = ALL_ONES;
                        cnt_d      = '0;
                        state_d    = ST_SWINIT;
                    end
                end
                ST_PFAIL: begin
                    state_d = ST_PFAIL;
                end
                ST_SWINIT: begin
                    if (cnt_q == INIT_LAST) begin
                        bus_init_d = 1'b0;
                        dev_init_d = '0;
                        cnt_d      = '0;
                        state_d    = ST_SWWAIT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_SWWAIT: begin
                    if (aclo_rise) begin
                        pwrfail_d = 1'b1;
                        cpu_run_d = 1'b1;
                        state_d   = ST_PFAIL;
                    end else if ((&dev_ready) || (cnt_q == TMO_LAST)) begin
                        if (!(&dev_ready)) timeout_d = 1'b1;
                        ack_d     = 1'b1;
                        cpu_run_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_RUN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_DCLO;
                end
            endcase
        end
    end

endmodule
